// File: rtl/lbp_gray_arb.sv
// Two-client read arbiter for the shared gray-image memory port.
// Round-robin grants with bounded bursts, one registered memory request and tagged return routing.
module lbp_gray_arb #(
    parameter int AW        = 14,
    parameter int DW        = 8,
    parameter int RD_LAT    = 1,
    parameter int MAX_BURST = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          c0_req,
    input  logic [AW-1:0] c0_addr,
    output logic          c0_gnt,
    output logic          c0_rvalid,
    output logic [DW-1:0] c0_rdata,
    input  logic          c1_req,
    input  logic [AW-1:0] c1_addr,
    output logic          c1_gnt,
    output logic          c1_rvalid,
    output logic [DW-1:0] c1_rdata,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_ready,
    input  logic [DW-1:0] mem_data,
    output logic          busy
);

    localparam int         NSTG      = RD_LAT + 1;
    localparam logic [3:0] BURST_LIM = 4'(MAX_BURST);
    localparam logic [3:0] BURST_SAT = 4'd15;

    logic [1:0]    req_vec;
    logic [AW-1:0] addr_arr [2];
    logic          gnt_any;
    logic          winner;
    logic [1:0]    gnt_vec;

    logic          last_owner_reg;
    logic          last_owner_next;
    logic [3:0]    burst_cnt_reg;
    logic [3:0]    burst_cnt_next;

    logic          mem_req_reg;
    logic [AW-1:0] mem_addr_reg;

    logic [NSTG-1:0] tag_valid_reg;
    logic [NSTG-1:0] tag_id_reg;
    logic            ret_valid;
    logic            ret_id;
    logic [1:0]      rvalid_vec;
    logic [DW-1:0]   rdata_out [2];

    assign req_vec     = {c1_req, c0_req};
    assign addr_arr[0] = c0_addr;
    assign addr_arr[1] = c1_addr;

    // A zero burst count means no burst is open yet, so contention goes to the non-last owner.
    always_comb begin
        gnt_any = 1'b0;
        winner  = 1'b0;
        if (!reset && mem_ready) begin
            case (req_vec)
                2'b01: begin
                    gnt_any = 1'b1;
                    winner  = 1'b0;
                end
                2'b10: begin
                    gnt_any = 1'b1;
                    winner  = 1'b1;
                end
                2'b11: begin
                    gnt_any = 1'b1;
                    if (burst_cnt_reg != 4'd0 && burst_cnt_reg < BURST_LIM) begin
                        winner = last_owner_reg;
                    end else begin
                        winner = ~last_owner_reg;
                    end
                end
                default: begin
                    gnt_any = 1'b0;
                    winner  = 1'b0;
                end
            endcase
        end
    end

    assign gnt_vec = {gnt_any & winner, gnt_any & ~winner};
    assign c0_gnt  = gnt_vec[0];
    assign c1_gnt  = gnt_vec[1];

    always_comb begin
        last_owner_next = last_owner_reg;
        burst_cnt_next  = burst_cnt_reg;
        if (gnt_any) begin
            if (winner == last_owner_reg) begin
                burst_cnt_next = (burst_cnt_reg == BURST_SAT) ? BURST_SAT : burst_cnt_reg + 4'd1;
            end else begin
                burst_cnt_next  = 4'd1;
                last_owner_next = winner;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_owner_reg <= 1'b1;
            burst_cnt_reg  <= 4'd0;
            mem_req_reg    <= 1'b0;
            mem_addr_reg   <= '0;
        end else begin
            last_owner_reg <= last_owner_next;
            burst_cnt_reg  <= burst_cnt_next;
            mem_req_reg    <= gnt_any;
            if (gnt_any) begin
                mem_addr_reg <= addr_arr[winner];
            end
        end
    end

    assign mem_req  = mem_req_reg;
    assign mem_addr = mem_addr_reg;

    // Stage k holds the tag of the read whose request is k cycles past mem_req; the last stage meets mem_data.
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_valid_reg <= '0;
            tag_id_reg    <= '0;
        end else begin
            tag_valid_reg[0] <= gnt_any;
            tag_id_reg[0]    <= winner;
            for (int i = 1; i < NSTG; i++) begin
                tag_valid_reg[i] <= tag_valid_reg[i-1];
                tag_id_reg[i]    <= tag_id_reg[i-1];
            end
        end
    end

    assign ret_valid = tag_valid_reg[RD_LAT] & ~reset;
    assign ret_id    = tag_id_reg[RD_LAT];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_client
            logic [DW-1:0] rdata_reg;

            assign rvalid_vec[gi] = ret_valid & (ret_id == 1'(gi));

            always_ff @(posedge clk) begin
                if (reset) begin
                    rdata_reg <= '0;
                end else if (rvalid_vec[gi]) begin
                    rdata_reg <= mem_data;
                end
            end

            assign rdata_out[gi] = rvalid_vec[gi] ? mem_data : rdata_reg;
        end
    endgenerate

    assign c0_rvalid = rvalid_vec[0];
    assign c1_rvalid = rvalid_vec[1];
    assign c0_rdata  = rdata_out[0];
    assign c1_rdata  = rdata_out[1];

    assign busy = gnt_any | mem_req_reg | (|tag_valid_reg);

endmodule
